seq_shift_alu: RTL and testbench

SEQ_SHIFT_ALU -- requirements
Module: seq_shift_alu

---
 rtl/seq_shift_alu_if.sv | 40 ++++
 rtl/seq_shift_alu.sv | 186 ++++++++++++++++++
 tb/tb_seq_shift_alu.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_shift_alu_if.sv
// seq_shift_alu_if
//   Request/response bundle for seq_shift_alu.
//   master : drives start/opcode/a/b/c_in, observes busy/done/y and flags.
//   slave  : the ALU side (inverse directions).
//   Ports carried:
//     start   request (sampled only while the ALU is idle)
//     opcode  operation select, OPW bits
//     a, b    operands, W bits (b doubles as the shift amount)
//     c_in    carry in
//     busy    high while the ALU is working
//     done    one-cycle completion pulse
//     y       registered result, W bits
//     c_out, v, n, z  carry, overflow, negative, zero flags
interface seq_shift_alu_if #(
  parameter int W   = 8,
  parameter int OPW = 4
);
  logic           start;
  logic [OPW-1:0] opcode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           c_in;
  logic           busy;
  logic           done;
  logic [W-1:0]   y;
  logic           c_out;
  logic           v;
  logic           n;
  logic           z;

  modport master (
    output start, opcode, a, b, c_in,
    input  busy, done, y, c_out, v, n, z
  );

  modport slave (
    input  start, opcode, a, b, c_in,
    output busy, done, y, c_out, v, n, z
  );
endinterface

// File: rtl/seq_shift_alu.sv
// seq_shift_alu
//   Multi-cycle shift/rotate/add/sub unit. A request is captured in IDLE,
//   shifts/rotates advance one bit per cycle in RUN, the result and flags
//   are registered when the shift count reaches zero, and DONE pulses done
//   for one cycle before returning to IDLE.
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset (clears all state and outputs)
//     bus    seq_shift_alu_if.slave (start/opcode/a/b/c_in in,
//            busy/done/y/c_out/v/n/z out)
module seq_shift_alu #(
  parameter int W   = 8,
  parameter int OPW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_shift_alu_if.slave  bus
);

  localparam int KW = $clog2(W + 1);
  localparam logic [W-1:0] W_VEC = W'(W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [2:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR, OP_ADD, OP_SUB} op_t;

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [W-1:0]  work_q, work_d;   // shift register; holds operand a for ADD/SUB
  logic [W-1:0]  b_q, b_d;
  logic          cin_q, cin_d;
  logic          carry_q, carry_d; // last bit shifted out, seeded with c_in
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  y_q, y_d;
  logic          c_out_q, c_out_d;
  logic          v_q, v_d;
  logic          n_q, n_d;
  logic          z_q, z_d;

  op_t           op_dec;
  logic [KW-1:0] k_init;
  logic [W-1:0]  b_eff;
  logic [W:0]    sum;
  logic          sum_v;

  // Opcode decode; unassigned codes fall back to LSL.
  always_comb begin
    op_dec = OP_LSL;
    case (bus.opcode)
      OPW'(1): op_dec = OP_LSR;
      OPW'(2): op_dec = OP_ASR;
      OPW'(3): op_dec = OP_ROL;
      OPW'(4): op_dec = OP_ROR;
      OPW'(5): op_dec = OP_ADD;
      OPW'(6): op_dec = OP_SUB;
      default: op_dec = OP_LSL;
    endcase
  end

  // Initial shift count: linear shifts saturate at W (result fully
  // shifted out), rotates wrap modulo W, arithmetic needs no shifting.
  always_comb begin
    k_init = '0;
    case (op_dec)
      OP_ROL, OP_ROR: k_init = KW'(bus.b % W_VEC);
      OP_ADD, OP_SUB: k_init = '0;
      default:        k_init = (bus.b >= W_VEC) ? KW'(W) : KW'(bus.b);
    endcase
  end

  // Adder: SUB is a + ~b + 1, so carry out high means no borrow.
  always_comb begin
    b_eff = (op_q == OP_SUB) ? ~b_q : b_q;
    sum   = {1'b0, work_q} + {1'b0, b_eff} + (W+1)'((op_q == OP_SUB) ? 1'b1 : cin_q);
    sum_v = (work_q[W-1] == b_eff[W-1]) && (sum[W-1] != work_q[W-1]);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    b_d     = b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    k_d     = k_q;
    y_d     = y_q;
    c_out_d = c_out_q;
    v_d     = v_q;
    n_d     = n_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = op_dec;
          work_d  = bus.a;
          b_d     = bus.b;
          cin_d   = bus.c_in;
          carry_d = bus.c_in;
          k_d     = k_init;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (k_q != '0) begin
          k_d = k_q - 1'b1;
          case (op_q)
            OP_LSR: begin
              work_d  = {1'b0, work_q[W-1:1]};
              carry_d = work_q[0];
            end
            OP_ASR: begin
              // The MSB never changes under ASR, so it is still captured a[W-1].
              work_d  = {work_q[W-1], work_q[W-1:1]};
              carry_d = work_q[0];
            end
            OP_ROL: begin
              work_d  = {work_q[W-2:0], work_q[W-1]};
              carry_d = work_q[W-1];
            end
            OP_ROR: begin
              work_d  = {work_q[0], work_q[W-1:1]};
              carry_d = work_q[0];
            end
            default: begin
              work_d  = {work_q[W-2:0], 1'b0};
              carry_d = work_q[W-1];
            end
          endcase
        end else begin
          if (op_q == OP_ADD || op_q == OP_SUB) begin
            y_d     = sum[W-1:0];
            c_out_d = sum[W];
            v_d     = sum_v;
          end else begin
            y_d     = work_q;
            c_out_d = carry_q;
            v_d     = 1'b0;
          end
          n_d     = y_d[W-1];
          z_d     = (y_d == '0);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_LSL;
      work_q  <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      k_q     <= '0;
      y_q     <= '0;
      c_out_q <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      y_q     <= y_d;
      c_out_q <= c_out_d;
      v_q     <= v_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end

  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = (state_q == S_DONE);
  assign bus.y     = y_q;
  assign bus.c_out = c_out_q;
  assign bus.v     = v_q;
  assign bus.n     = n_q;
  assign bus.z     = z_q;

endmodule

// File: tb/tb_seq_shift_alu.sv
// tb_seq_shift_alu
//   Scoreboard bench for seq_shift_alu (W=8). The driver pushes the expected
//   result and completion cycle when a request is accepted; the monitor pops
//   and compares whenever done is seen.
module tb_seq_shift_alu;
  localparam int W   = 8;
  localparam int OPW = 4;

  typedef struct {
    int         op;
    int         a;
    int         b;
    logic [7:0] y;
    logic       c;
    logic       v;
    logic       n;
    logic       z;
    int         done_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_shift_alu_if #(.W(W), .OPW(OPW)) ifc ();
  seq_shift_alu #(.W(W), .OPW(OPW)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic neg();
    @(negedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int op, a, b, input logic [7:0] y, input logic c, v);
    exp_t e;
    e.op = op; e.a = a; e.b = b;
    e.y = y; e.c = c; e.v = v; e.n = y[7]; e.z = (y == 8'h00);
    e.done_cyc = 0;
    return e;
  endfunction

  // Reference: each opcode's result written as whole-word arithmetic.
  function automatic exp_t model(input int op, a, b, cin, output int k);
    int sa, sbv, s, sv, r, c;
    logic v;
    sa  = (a >= 128) ? a - 256 : a;
    sbv = (b >= 128) ? b - 256 : b;
    v   = 1'b0;
    k   = (b > 8) ? 8 : b;
    case (op)
      5: begin
        k = 0; s = a + b + cin; r = s & 255; c = (s >> 8) & 1;
        sv = sa + sbv + cin; v = (sv > 127) || (sv < -128);
      end
      6: begin
        k = 0; s = a + (255 - b) + 1; r = s & 255; c = (s >> 8) & 1;
        sv = sa - sbv; v = (sv > 127) || (sv < -128);
      end
      1: begin
        r = a >> k; c = (k == 0) ? cin : ((a >> (k - 1)) & 1);
      end
      2: begin
        r = (sa >>> k) & 255; c = (k == 0) ? cin : ((sa >>> (k - 1)) & 1);
      end
      3: begin
        k = b % 8; r = ((a << k) | (a >> (8 - k))) & 255;
        c = (k == 0) ? cin : (r & 1);
      end
      4: begin
        k = b % 8; r = ((a >> k) | (a << (8 - k))) & 255;
        c = (k == 0) ? cin : ((r >> 7) & 1);
      end
      default: begin
        r = (a << k) & 255; c = (k == 0) ? cin : ((a >> (8 - k)) & 1);
      end
    endcase
    return mk(op, a, b, r[7:0], c[0], v);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ifc.done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        $display("op=%0d a=%02h b=%02h -> y=%02h c=%0b v=%0b n=%0b z=%0b cyc=%0d",
                 e.op, e.a, e.b, ifc.y, ifc.c_out, ifc.v, ifc.n, ifc.z, cyc);
        check("result", 32'({ifc.y, ifc.c_out, ifc.v, ifc.n, ifc.z}),
              32'({e.y, e.c, e.v, e.n, e.z}));
        check("latency", 32'(cyc), 32'(e.done_cyc));
        check("busy_at_done", 32'(ifc.busy), 32'(0));
      end
    end
  end

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && n_done < target; i++) neg();
    if (n_done < target) begin
      check("done_timeout", 32'(n_done), 32'(target));
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  task automatic check_hold(input exp_t e);
    check("idle_after_done", 32'({ifc.busy, ifc.done}), 32'(0));
    check("hold", 32'({ifc.y, ifc.c_out, ifc.v, ifc.n, ifc.z}),
          32'({e.y, e.c, e.v, e.n, e.z}));
  endtask

  // Caller is at a negedge+1 point with the DUT idle.
  task automatic run_op(input int op, a, b, cin, input exp_t e, input int k);
    int t;
    int target;
    target = n_done + 1;
    ifc.start = 1'b1; ifc.opcode = OPW'(op); ifc.a = 8'(a); ifc.b = 8'(b); ifc.c_in = cin[0];
    @(posedge clk); #1;
    t = cyc;
    e.done_cyc = t + k + 1;
    sb.push_back(e);
    neg();
    ifc.start = 1'b0;
    ifc.a = 8'($urandom); ifc.b = 8'($urandom); ifc.c_in = 1'($urandom); ifc.opcode = 4'($urandom);
    check("busy_in_run", 32'(ifc.busy), 32'(1));
    neg();
    ifc.start = 1'b1;  // lands in RUN or DONE, must be ignored
    ifc.a = 8'($urandom); ifc.b = 8'($urandom);
    neg();
    ifc.start = 1'b0;
    wait_done(target, 40);
    neg();
    check_hold(e);
  endtask

  // start held high: the same request repeats every k+3 cycles.
  task automatic run_hold(input int op, a, b, cin, input int reps);
    exp_t e;
    int k, t0, target;
    e = model(op, a, b, cin, k);
    target = n_done + reps;
    ifc.start = 1'b1; ifc.opcode = OPW'(op); ifc.a = 8'(a); ifc.b = 8'(b); ifc.c_in = cin[0];
    @(posedge clk); #1;
    t0 = cyc;
    for (int r = 0; r < reps; r++) begin
      e.done_cyc = t0 + r * (k + 3) + k + 1;
      sb.push_back(e);
    end
    for (int i = 0; i < 40 * reps && n_done < target; i++) neg();
    ifc.start = 1'b0;
    if (n_done < target) begin
      check("hold_timeout", 32'(n_done), 32'(target));
      while (sb.size() > 0) void'(sb.pop_front());
    end
    neg();
    neg();
    check_hold(e);
  endtask

  task automatic rand_op();
    int op, a, b, cin, k;
    exp_t e;
    op  = $urandom_range(0, 15);
    a   = $urandom_range(0, 255);
    b   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : $urandom_range(0, 255);
    cin = $urandom_range(0, 1);
    e   = model(op, a, b, cin, k);
    run_op(op, a, b, cin, e, k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.start = 1'b0; ifc.opcode = '0; ifc.a = '0; ifc.b = '0; ifc.c_in = 1'b0;
    neg();
    neg();
    check("reset_outputs", 32'({ifc.busy, ifc.done, ifc.y, ifc.c_out, ifc.v, ifc.n, ifc.z}), 32'(0));
    rst_n = 1'b1;
    neg();
    check("idle_no_busy", 32'({ifc.busy, ifc.done}), 32'(0));

    // Directed cases with hand-derived expectations (op, a, b, cin, y, c, v, k).
    run_op(0, 8'h81, 1,  0, mk(0, 8'h81, 1,  8'h02, 1'b1, 1'b0), 1);
    run_op(2, 8'h80, 10, 0, mk(2, 8'h80, 10, 8'hFF, 1'b1, 1'b0), 8);
    run_op(5, 8'h7F, 1,  0, mk(5, 8'h7F, 1,  8'h80, 1'b0, 1'b1), 0);
    run_op(6, 8'h00, 1,  0, mk(6, 8'h00, 1,  8'hFF, 1'b0, 1'b0), 0);
    run_op(4, 8'h01, 9,  0, mk(4, 8'h01, 9,  8'h80, 1'b1, 1'b0), 1);
    run_op(0, 8'h5A, 0,  1, mk(0, 8'h5A, 0,  8'h5A, 1'b1, 1'b0), 0);
    run_op(5, 8'hFF, 1,  0, mk(5, 8'hFF, 1,  8'h00, 1'b1, 1'b0), 0);
    run_op(15, 8'h0F, 4, 0, mk(15, 8'h0F, 4, 8'hF0, 1'b0, 1'b0), 4);
    run_op(1, 8'h80, 8,  1, mk(1, 8'h80, 8,  8'h00, 1'b1, 1'b0), 8);
    run_op(3, 8'h81, 1,  0, mk(3, 8'h81, 1,  8'h03, 1'b1, 1'b0), 1);

    // start held continuously
    run_hold(5, 8'h10, 8'h20, 1, 3);
    run_hold(3, 8'hA5, 3, 0, 2);

    // Reset mid-RUN: outputs clear immediately, the aborted op never completes.
    ifc.start = 1'b1; ifc.opcode = 4'd2; ifc.a = 8'h80; ifc.b = 8'd8; ifc.c_in = 1'b0;
    @(posedge clk); #1;
    neg();
    ifc.start = 1'b0;
    neg();
    neg();
    check("busy_before_reset", 32'(ifc.busy), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({ifc.busy, ifc.done, ifc.y, ifc.c_out, ifc.v, ifc.n, ifc.z}), 32'(0));
    neg();
    neg();
    check("held_reset_outputs", 32'({ifc.busy, ifc.done, ifc.y, ifc.c_out, ifc.v, ifc.n, ifc.z}), 32'(0));
    rst_n = 1'b1;
    // First edge after release with start=1 must be accepted.
    run_op(0, 8'h81, 1, 0, mk(0, 8'h81, 1, 8'h02, 1'b1, 1'b0), 1);

    for (int i = 0; i < 60; i++) rand_op();

    neg();
    neg();
    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
